sort_floats_seq: RTL and testbench
==================================

SORT_FLOATS_SEQ -- requirements
Module: sort_floats_seq

Interface
REQ-001 Parameter: N, default 4, number of FLEN-bit floating-point elements sorted per job; legal range 2..16.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: up_valid  input  1  input job present.
REQ-005 Port: up_ready  output  1  block can accept a job.
REQ-006 Port: up_data  input  [0:N-1][FLEN-1:0]  unsorted elements; element 0 first.
REQ-007 Port: down_valid  output  1  sorted result present.
REQ-008 Port: down_ready  input  1  consumer accepts the result.
REQ-009 Port: down_data  output  [0:N-1][FLEN-1:0]  result; down_data[i] <= down_data[i+1] for all i when down_err=0.
REQ-010 Port: down_err  output  1  at least one comparison during the job flagged an error (NaN operand).

Function
REQ-011 States SHALL be IDLE, SORT and DONE; up_ready SHALL equal (state==IDLE); down_valid SHALL equal (state==DONE).
REQ-012 IDLE with up_valid=1 SHALL latch up_data into an internal N-entry register array, clear the error flag and phase counter, and enter SORT.
REQ-013 SORT SHALL perform one odd-even transposition phase per cycle: even phase (phase counter bit0=0) compares pairs (0,1),(2,3),...; odd phase compares pairs (1,2),(3,4),... while the upper index is < N.
REQ-014 Hardware SHALL use exactly floor(N/2) f_less_or_equal instances, shared between even and odd phases via input muxing.
REQ-015 For each active pair (a=lower index, b=upper index): res=0 and err=0 SHALL swap the pair; res=1 or err=1 SHALL leave it unchanged.
REQ-016 err from an active comparator SHALL be ORed into a sticky job error flag; err from an instance inactive in the current odd phase SHALL be ignored.
REQ-017 Without early exit, SORT SHALL last exactly N cycles (phases 0..N-1), then transition to DONE; down_valid SHALL rise N rising edges after the accepting edge.
REQ-018 DONE SHALL hold down_data and down_err stable until down_ready=1, then return to IDLE; no new job is accepted in that same cycle.
REQ-019 up_data changes during SORT/DONE SHALL have no effect on the active job.
REQ-020 Equal operands (including +0/-0 where f_less_or_equal reports res=1) SHALL not be swapped, so equal keys keep input order.

Reset
REQ-021 rst_n=0 SHALL immediately force state IDLE, phase counter 0, error flag 0, and data array all-zero; hence up_ready=1, down_valid=0, down_data=0, down_err=0.
REQ-022 rst_n asserted during SORT or DONE SHALL abort the job without producing a result; the first job after release SHALL be processed normally.

Configuration
REQ-023 Macro SORT_FLOATS_SEQ_EARLY_EXIT_EN: when defined, SORT SHALL also end after any two consecutive phases (one even, one odd) with zero swaps, entering DONE at the edge closing the second; minimum SORT duration 2 cycles, maximum N.
REQ-024 When SORT_FLOATS_SEQ_EARLY_EXIT_EN is undefined, swap-tracking logic SHALL be absent and SORT duration SHALL be exactly N cycles regardless of data.
REQ-025 Both builds SHALL produce identical down_data and down_err for every input; only latency differs.

Verification (N=4, FP64 hex)
REQ-026 Reversed input {4010...(4.0), 4008...(3.0), 4000...(2.0), 3FF0...(1.0)} accepted -> down_valid after 4 edges; down_data={1.0,2.0,3.0,4.0}, down_err=0.
REQ-027 Sorted input {BFF0...(-1.0), 0, 3FF0..., 4000...} -> same data returned; down_valid after 2 edges with EARLY_EXIT_EN, after 4 edges without.
REQ-028 Input containing NaN 7FF8000000000000 at element 1 with other values {3.0,-,1.0,2.0} -> down_err=1; non-NaN order not checked; down_valid timing per REQ-017/023.
REQ-029 down_ready held 0 for 10 cycles in DONE -> down_data/down_valid stable, up_ready=0 throughout; down_ready=1 -> IDLE next edge, up_ready=1.
REQ-030 rst_n pulsed low in second SORT cycle -> outputs zero immediately, down_valid never asserts for that job; next job {2.0,1.0,1.0,0} -> {0,1.0,1.0,2.0}.
REQ-031 Back-to-back: up_valid held 1 with two jobs -> second accepted only in IDLE after first result handshake; both results correct.

Source files
------------

// File: rtl/sort_floats_seq.sv
// -----------------------------------------------------------------------------
// sort_floats_seq
//   Sequential odd-even transposition sorter for N IEEE-754 floating-point
//   values of FLEN bits (FLEN = 16, 32, 64 or 128). A job is latched from
//   up_data in IDLE. SORT then runs one transposition phase per cycle on
//   floor(N/2) shared comparators. DONE presents the result until the
//   consumer takes it.
//
//   Ports
//     clk         rising-edge clock
//     rst_n       asynchronous active-low reset
//     up_valid    job offered on up_data
//     up_ready    block is idle and accepts a job
//     up_data     N unsorted elements, element 0 first
//     down_valid  sorted result present on down_data / down_err
//     down_ready  consumer takes the result
//     down_data   ascending elements (order undefined when down_err = 1)
//     down_err    a comparison during the job saw a NaN operand
//
//   Build option
//     SORT_FLOATS_SEQ_EARLY_EXIT_EN : leave SORT after two consecutive phases
//     (one even, one odd) that made no swaps. The array is then at a fixed
//     point, so the result equals the full N-phase run; only latency changes.
// -----------------------------------------------------------------------------

// IEEE-754 "a <= b". A NaN on either side raises err and forces res = 0.
// +0 and -0 compare equal.
module f_less_or_equal #(
    parameter int FLEN = 64
) (
    input  logic [FLEN-1:0] a,
    input  logic [FLEN-1:0] b,
    output logic            res,
    output logic            err
);
    localparam int EW = (FLEN == 16) ? 5 : (FLEN == 32) ? 8 : (FLEN == 128) ? 15 : 11;
    // Magnitude of +infinity. Any larger magnitude is a NaN.
    localparam logic [FLEN-2:0] INF_MAG = {{EW{1'b1}}, {(FLEN-1-EW){1'b0}}};

    logic            sign_a, sign_b;
    logic [FLEN-2:0] mag_a, mag_b;
    logic            nan_a, nan_b;

    assign sign_a = a[FLEN-1];
    assign sign_b = b[FLEN-1];
    assign mag_a  = a[FLEN-2:0];
    assign mag_b  = b[FLEN-2:0];
    assign nan_a  = mag_a > INF_MAG;
    assign nan_b  = mag_b > INF_MAG;

    always_comb begin
        // NOTE: outputs get defaults first so every path assigns them; a
        // missing assignment on any branch would infer a latch.
        res = 1'b0;
        err = 1'b0;
        if (nan_a || nan_b) begin
            err = 1'b1;
        end else if (mag_a == '0 && mag_b == '0) begin
            res = 1'b1;                      // +0 / -0 are equal
        end else if (sign_a != sign_b) begin
            res = sign_a;                    // negative a sits below positive b
        end else if (!sign_a) begin
            res = (mag_a <= mag_b);
        end else begin
            res = (mag_a >= mag_b);          // both negative: larger magnitude is smaller
        end
    end
endmodule

module sort_floats_seq #(
    parameter int N    = 4,
    parameter int FLEN = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     up_valid,
    output logic                     up_ready,
    input  logic [0:N-1][FLEN-1:0]   up_data,
    output logic                     down_valid,
    input  logic                     down_ready,
    output logic [0:N-1][FLEN-1:0]   down_data,
    output logic                     down_err
);
    localparam int NP = N / 2;          // comparator count
    localparam int PW = $clog2(N);      // phase counter width
    localparam logic [PW-1:0] LAST_PHASE = PW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   phase_q;
    logic            err_q;
    logic            phase_odd;
    logic            load;
    logic            step;

    logic [FLEN-1:0] elem_q [N];
    logic [FLEN-1:0] op_a   [NP];
    logic [FLEN-1:0] op_b   [NP];
    logic [NP-1:0]   cmp_res;
    logic [NP-1:0]   cmp_err;
    logic [NP-1:0]   cmp_act;
    logic [NP-1:0]   do_swap;
    logic            any_err;

`ifdef SORT_FLOATS_SEQ_EARLY_EXIT_EN
    logic            any_swap;
    logic            quiet_q;           // previous phase of this job made no swap
    assign any_swap = |do_swap;
`endif

    assign phase_odd  = phase_q[0];
    assign load       = (state_q == IDLE) && up_valid;
    assign step       = (state_q == SORT);
    assign any_err    = |(cmp_err & cmp_act);
    assign up_ready   = (state_q == IDLE);
    assign down_valid = (state_q == DONE);
    assign down_err   = err_q;

    // ---------------------------------------------------------------------
    // Comparators. Instance k serves pair (2k, 2k+1) in even phases and
    // pair (2k+1, 2k+2) in odd phases. The last instance idles in odd phases
    // when N is even, because 2k+2 would fall off the array.
    // ---------------------------------------------------------------------
    for (genvar k = 0; k < NP; k++) begin : g_cmp
        if (2 * k + 2 < N) begin : g_shared
            assign op_a[k]    = phase_odd ? elem_q[2*k+1] : elem_q[2*k];
            assign op_b[k]    = phase_odd ? elem_q[2*k+2] : elem_q[2*k+1];
            assign cmp_act[k] = 1'b1;
        end else begin : g_even_only
            assign op_a[k]    = elem_q[2*k];
            assign op_b[k]    = elem_q[2*k+1];
            assign cmp_act[k] = ~phase_odd;
        end

        f_less_or_equal #(.FLEN(FLEN)) u_cmp (
            .a   (op_a[k]),
            .b   (op_b[k]),
            .res (cmp_res[k]),
            .err (cmp_err[k])
        );

        // Swap only a strictly out-of-order, NaN-free pair. Equal keys stay
        // in place, which keeps the sort stable.
        assign do_swap[k] = cmp_act[k] & ~cmp_res[k] & ~cmp_err[k];
    end

    // ---------------------------------------------------------------------
    // Element registers. Each element picks its own value or its partner's,
    // depending on the phase and on the swap decision of that pair.
    // ---------------------------------------------------------------------
    for (genvar j = 0; j < N; j++) begin : g_elem
        logic [FLEN-1:0] even_val;
        logic [FLEN-1:0] odd_val;

        if (j % 2 == 1) begin : g_even_hi
            assign even_val = do_swap[j/2] ? elem_q[j-1] : elem_q[j];
        end else if (j + 1 < N) begin : g_even_lo
            assign even_val = do_swap[j/2] ? elem_q[j+1] : elem_q[j];
        end else begin : g_even_none
            assign even_val = elem_q[j];
        end

        if (j % 2 == 1 && j + 1 < N) begin : g_odd_lo
            assign odd_val = do_swap[(j-1)/2] ? elem_q[j+1] : elem_q[j];
        end else if (j % 2 == 0 && j >= 2) begin : g_odd_hi
            assign odd_val = do_swap[(j-2)/2] ? elem_q[j-1] : elem_q[j];
        end else begin : g_odd_none
            assign odd_val = elem_q[j];
        end

        // NOTE: this storage array is reset on purpose, so that down_data
        // reads zero during and right after reset. Plain storage arrays are
        // normally left without a reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                elem_q[j] <= '0;
            end else if (load) begin
                elem_q[j] <= up_data[j];
            end else if (step) begin
                elem_q[j] <= phase_odd ? odd_val : even_val;
            end
        end

        assign down_data[j] = elem_q[j];
    end

    // ---------------------------------------------------------------------
    // Control state
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples values from before the edge.
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                phase_q <= '0;
                err_q   <= 1'b0;
            end else if (step) begin
                phase_q <= phase_q + 1'b1;
                err_q   <= err_q | any_err;
            end
        end
    end

`ifdef SORT_FLOATS_SEQ_EARLY_EXIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quiet_q <= 1'b0;
        end else if (load) begin
            quiet_q <= 1'b0;
        end else if (step) begin
            quiet_q <= ~any_swap;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (up_valid) state_d = SORT;
            SORT: begin
                if (phase_q == LAST_PHASE) begin
                    state_d = DONE;
`ifdef SORT_FLOATS_SEQ_EARLY_EXIT_EN
                end else if (quiet_q && !any_swap) begin
                    // Two quiet phases in a row: the array is a fixed point.
                    state_d = DONE;
`endif
                end
            end
            DONE: if (down_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sort_floats_seq.sv
// -----------------------------------------------------------------------------
// tb_sort_floats_seq
//   Self-checking bench for sort_floats_seq with N = 4 and FLEN = 64. The
//   expected results come from a stable insertion sort over real values.
//   NaN jobs are checked only for the error flag.
// -----------------------------------------------------------------------------
module tb_sort_floats_seq;
    localparam int N    = 4;
    localparam int FLEN = 64;
    localparam int W    = N * FLEN;

    typedef logic [0:N-1][FLEN-1:0] vec_t;

    localparam logic [FLEN-1:0] QNAN   = 64'h7FF8000000000000;
    localparam logic [FLEN-1:0] NEG_Z  = 64'h8000000000000000;

    logic clk        = 1'b0;
    logic rst_n      = 1'b0;
    logic up_valid   = 1'b0;
    logic down_ready = 1'b0;
    vec_t up_data    = '0;
    logic up_ready;
    logic down_valid;
    logic down_err;
    vec_t down_data;

    int checks   = 0;
    int failures = 0;

    sort_floats_seq #(.N(N), .FLEN(FLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data),
        .down_err   (down_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [FLEN-1:0] fp(input real r);
        return $realtobits(r);
    endfunction

    // Stable ascending sort: each value goes after every element that is
    // not greater than it. Real compare treats +0 and -0 as equal.
    function automatic vec_t ref_sort(input vec_t v);
        logic [FLEN-1:0] q[$];
        vec_t r;
        for (int i = 0; i < N; i++) begin
            int p = q.size();
            for (int s = 0; s < q.size(); s++) begin
                if ($bitstoreal(q[s]) > $bitstoreal(v[i])) begin
                    p = s;
                    break;
                end
            end
            q.insert(p, v[i]);
        end
        for (int i = 0; i < N; i++) r[i] = q[i];
        return r;
    endfunction

    function automatic logic [FLEN-1:0] rnd_val();
        int sel = int'($urandom_range(0, 9));
        if (sel == 0) return '0;
        if (sel == 1) return NEG_Z;
        return fp(real'(int'($urandom_range(0, 16)) - 8) / 2.0);
    endfunction

    task automatic check_latency(input string tag, input int lat);
`ifdef SORT_FLOATS_SEQ_EARLY_EXIT_EN
        check(tag, W'(lat >= 2 && lat <= N), W'(1));
`else
        check(tag, W'(lat), W'(N));
`endif
    endtask

    // Offer one job, count edges from the accepting edge to down_valid, keep
    // DONE for `hold` cycles (with up_valid also high), then hand shake.
    task automatic run_job(input string tag, input vec_t d, input int hold,
                           output int lat, output vec_t res, output logic err);
        int n = 0;
        while (!up_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_ready"}, W'(up_ready), W'(1));
        up_data  = d;
        up_valid = 1'b1;
        @(posedge clk); #1;
        up_valid = 1'b0;
        up_data  = {N{64'hDEAD_BEEF_0BAD_F00D}};
        lat = 0;
        while (!down_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        res = down_data;
        err = down_err;
        up_valid = (hold > 0);
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, W'(down_valid), W'(1));
            check({tag, "_hold_data"},  W'(down_data),  W'(res));
            check({tag, "_hold_ready"}, W'(up_ready),   W'(0));
        end
        down_ready = 1'b1;
        @(posedge clk); #1;
        down_ready = 1'b0;
        check({tag, "_back_idle"}, W'(up_ready),   W'(1));
        check({tag, "_no_valid"},  W'(down_valid), W'(0));
        up_valid = 1'b0;
    endtask

    initial begin
        int   lat;
        vec_t res;
        logic err;
        vec_t job_a, job_b;
        logic seen_valid;

        // Reset state
        #12;
        check("rst_up_ready",   W'(up_ready),   W'(1));
        check("rst_down_valid", W'(down_valid), W'(0));
        check("rst_down_err",   W'(down_err),   W'(0));
        check("rst_down_data",  W'(down_data),  W'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reversed input, result held 10 cycles before the handshake
        job_a = {fp(4.0), fp(3.0), fp(2.0), fp(1.0)};
        run_job("rev", job_a, 10, lat, res, err);
        check("rev_lat",  W'(lat), W'(N));
        check("rev_data", W'(res), W'(vec_t'({fp(1.0), fp(2.0), fp(3.0), fp(4.0)})));
        check("rev_err",  W'(err), W'(0));

        // Already sorted input
        job_a = {fp(-1.0), 64'h0, fp(1.0), fp(2.0)};
        run_job("sorted", job_a, 0, lat, res, err);
`ifdef SORT_FLOATS_SEQ_EARLY_EXIT_EN
        check("sorted_lat", W'(lat), W'(2));
`else
        check("sorted_lat", W'(lat), W'(N));
`endif
        check("sorted_data", W'(res), W'(job_a));
        check("sorted_err",  W'(err), W'(0));

        // NaN at element 1
        job_a = {fp(3.0), QNAN, fp(1.0), fp(2.0)};
        run_job("nan", job_a, 0, lat, res, err);
        check_latency("nan_lat", lat);
        check("nan_err", W'(err), W'(1));

        // Reset during the second SORT cycle
        up_data  = {fp(5.0), fp(-3.0), fp(7.0), fp(0.5)};
        up_valid = 1'b1;
        @(posedge clk); #1;
        up_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_up_ready",   W'(up_ready),   W'(1));
        check("abort_down_valid", W'(down_valid), W'(0));
        check("abort_down_data",  W'(down_data),  W'(0));
        check("abort_down_err",   W'(down_err),   W'(0));
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            seen_valid |= down_valid;
        end
        check("abort_no_result", W'(seen_valid), W'(0));
        job_a = {fp(2.0), fp(1.0), fp(1.0), 64'h0};
        run_job("post_rst", job_a, 0, lat, res, err);
        check("post_rst_lat",  W'(lat), W'(N));
        check("post_rst_data", W'(res), W'(vec_t'({64'h0, fp(1.0), fp(1.0), fp(2.0)})));
        check("post_rst_err",  W'(err), W'(0));

        // Back-to-back with up_valid held high; up_data switches to job B
        // while job A is in flight.
        job_a = {fp(-2.5), fp(6.0), NEG_Z, 64'h0};
        job_b = {fp(9.0), fp(-9.0), fp(0.5), fp(-0.5)};
        up_data  = job_a;
        up_valid = 1'b1;
        @(posedge clk); #1;
        up_data = job_b;
        lat = 0;
        while (!down_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check_latency("b2b_a_lat", lat);
        check("b2b_a_data",  W'(down_data), W'(ref_sort(job_a)));
        check("b2b_a_ready", W'(up_ready),  W'(0));
        down_ready = 1'b1;
        @(posedge clk); #1;
        down_ready = 1'b0;
        check("b2b_idle_between", W'(up_ready), W'(1));
        @(posedge clk); #1;
        check("b2b_b_taken", W'(up_ready), W'(0));
        up_valid = 1'b0;
        lat = 0;
        while (!down_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check_latency("b2b_b_lat", lat);
        check("b2b_b_data", W'(down_data), W'(ref_sort(job_b)));
        check("b2b_b_err",  W'(down_err),  W'(0));
        down_ready = 1'b1;
        @(posedge clk); #1;
        down_ready = 1'b0;

        // Randomised jobs against the reference model
        for (int t = 0; t < 30; t++) begin
            logic has_nan;
            for (int i = 0; i < N; i++) job_a[i] = rnd_val();
            has_nan = (t % 6 == 5);
            if (has_nan) job_a[$urandom_range(0, N-1)] = QNAN;
            run_job($sformatf("rnd%0d", t), job_a, 0, lat, res, err);
            check_latency($sformatf("rnd%0d_lat", t), lat);
            check($sformatf("rnd%0d_err", t), W'(err), W'(has_nan));
            if (!has_nan) check($sformatf("rnd%0d_data", t), W'(res), W'(ref_sort(job_a)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
